// File: rtl/instr_mem_pkg.sv
// Shared definitions for the loadable instruction memory: opcode encodings,
// loader FSM state and the multiplication demo program image that is placed
// in the array when INSTR_MEM_DEMO_PROG_EN is defined.
package instr_mem_pkg;

    // Instruction format: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt/imm
    localparam logic [3:0] OP_ADD = 4'h5;
    localparam logic [3:0] OP_SUB = 4'h6;
    localparam logic [3:0] OP_LW  = 4'h8;
    localparam logic [3:0] OP_SW  = 4'h9;
    localparam logic [3:0] OP_BNE = 4'hC;
    localparam logic [3:0] OP_J   = 4'hF;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    // Multiplication demo: R1 = R2 * R3 by repeated addition, result stored
    // to data memory, read back and copied, then park in a jump loop.
    localparam logic [15:0] DEMO_W0  = {OP_SUB, 4'd0, 4'd0, 4'd0};  // sub r0,r0,r0
    localparam logic [15:0] DEMO_W1  = {OP_SUB, 4'd1, 4'd1, 4'd1};  // sub r1,r1,r1
    localparam logic [15:0] DEMO_W2  = {OP_LW,  4'd2, 4'd0, 4'd0};  // lw  r2,0(r0)
    localparam logic [15:0] DEMO_W3  = {OP_LW,  4'd3, 4'd0, 4'd1};  // lw  r3,1(r0)
    localparam logic [15:0] DEMO_W4  = {OP_LW,  4'd4, 4'd0, 4'd2};  // lw  r4,2(r0)
    localparam logic [15:0] DEMO_W5  = {OP_ADD, 4'd1, 4'd1, 4'd2};  // add r1,r1,r2
    localparam logic [15:0] DEMO_W6  = {OP_SUB, 4'd3, 4'd3, 4'd4};  // sub r3,r3,r4
    localparam logic [15:0] DEMO_W7  = {OP_BNE, 4'd3, 4'd0, 4'hD};  // bne r3,r0,-3
    localparam logic [15:0] DEMO_W8  = {OP_SW,  4'd1, 4'd0, 4'd3};  // sw  r1,3(r0)
    localparam logic [15:0] DEMO_W9  = {OP_LW,  4'd5, 4'd0, 4'd3};  // lw  r5,3(r0)
    localparam logic [15:0] DEMO_W10 = {OP_SW,  4'd5, 4'd0, 4'd4};  // sw  r5,4(r0)
    localparam logic [15:0] DEMO_W11 = {OP_J,   12'd31};            // j 31
    localparam logic [15:0] DEMO_W31 = {OP_J,   12'd0};             // j 0

endpackage

// File: rtl/instr_ram.sv
// Simple dual-port instruction array: synchronous write port for the loader,
// synchronous read port for fetch. rdata is cleared by rst so the fetch
// output starts at zero. Contents at configuration depend on the macro
// INSTR_MEM_DEMO_PROG_EN (demo program) or are all zero otherwise; the
// array itself is never cleared by reset.
module instr_ram
    import instr_mem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

`ifdef INSTR_MEM_DEMO_PROG_EN
    logic [DATA_W-1:0] mem [DEPTH] = '{
        0:  DATA_W'(DEMO_W0),
        1:  DATA_W'(DEMO_W1),
        2:  DATA_W'(DEMO_W2),
        3:  DATA_W'(DEMO_W3),
        4:  DATA_W'(DEMO_W4),
        5:  DATA_W'(DEMO_W5),
        6:  DATA_W'(DEMO_W6),
        7:  DATA_W'(DEMO_W7),
        8:  DATA_W'(DEMO_W8),
        9:  DATA_W'(DEMO_W9),
        10: DATA_W'(DEMO_W10),
        11: DATA_W'(DEMO_W11),
        31: DATA_W'(DEMO_W31),
        default: '0
    };
`else
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
`endif

    // Loader write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Fetch read port; holds its value when no read is requested
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_mem_loadable.sv
// Instruction memory with an in-system program loader. RUN serves fetches
// with one cycle of latency; LOAD accepts a valid/ready stream of words
// written from address 0 upward and finishes on load_last or at the top
// address. Optional configuration macro: INSTR_MEM_DEMO_PROG_EN.
module instr_mem_loadable
    import instr_mem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              fetch_en,
    output logic [DATA_W-1:0] instruction,
    output logic              instr_valid,
    output logic              busy,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done
);

    localparam logic [ADDR_W-1:0] WPTR_MAX = '1;

    state_t            state;
    logic [ADDR_W-1:0] wptr;
    logic              beat;
    logic              rd_en;

    // A load beat needs the registered ready; reset in the same cycle wins.
    assign beat  = load_valid && load_ready && !rst;
    // load_start takes priority over a fetch in the same cycle.
    assign rd_en = fetch_en && (state == ST_RUN) && !load_start;

    instr_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (beat),
        .waddr (wptr),
        .wdata (load_data),
        .re    (rd_en),
        .raddr (pc),
        .rdata (instruction)
    );

    // Loader FSM with registered handshake, status and fetch-valid outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            wptr        <= '0;
            busy        <= 1'b0;
            load_ready  <= 1'b0;
            load_done   <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            load_done <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (load_start) begin
                        state       <= ST_LOAD;
                        wptr        <= '0;
                        busy        <= 1'b1;
                        load_ready  <= 1'b1;
                        instr_valid <= 1'b0;
                    end else begin
                        instr_valid <= fetch_en;
                    end
                end
                ST_LOAD: begin
                    instr_valid <= 1'b0;
                    if (beat) begin
                        if (load_last || (wptr == WPTR_MAX)) begin
                            state      <= ST_RUN;
                            busy       <= 1'b0;
                            load_ready <= 1'b0;
                            load_done  <= 1'b1;
                        end
                        // Pointer saturates at the top address instead of wrapping
                        if (wptr != WPTR_MAX) begin
                            wptr <= wptr + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule
